// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward-select
// codes, register-index width and the "same non-zero register" helper.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        SYS_DRAIN = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // $0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_match(input reg_idx_t dst, input reg_idx_t src);
        return (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational dependency checks: load-use stall, branch-operand stall and
// forwarding selects for the E-stage ALU and the D-stage branch comparator.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] rs_d_i,
    input  logic [REG_W-1:0] rt_d_i,
    input  logic [REG_W-1:0] rs_e_i,
    input  logic [REG_W-1:0] rt_e_i,
    input  logic [REG_W-1:0] write_reg_e_i,
    input  logic [REG_W-1:0] write_reg_m_i,
    input  logic [REG_W-1:0] write_reg_w_i,
    input  logic             reg_write_e_i,
    input  logic             reg_write_m_i,
    input  logic             reg_write_w_i,
    input  logic             mem_to_reg_e_i,
    input  logic             mem_to_reg_m_i,
    input  logic             branch_d_i,
    output logic             load_use_o,
    output logic             branch_stall_o,
    output logic [1:0]       forward_a_e_o,
    output logic [1:0]       forward_b_e_o,
    output logic             forward_a_d_o,
    output logic             forward_b_d_o
);

    logic e_hits_d;
    logic m_hits_d;

    assign e_hits_d = reg_match(write_reg_e_i, rs_d_i) || reg_match(write_reg_e_i, rt_d_i);
    assign m_hits_d = reg_match(write_reg_m_i, rs_d_i) || reg_match(write_reg_m_i, rt_d_i);

    assign load_use_o     = mem_to_reg_e_i && e_hits_d;
    // The branch compares in D, so any in-flight producer it cannot forward from must stall it.
    assign branch_stall_o = branch_d_i && ((reg_write_e_i && e_hits_d) ||
                                           (mem_to_reg_m_i && m_hits_d));

    always_comb begin
        forward_a_e_o = FWD_RF;
        if (reg_write_m_i && reg_match(write_reg_m_i, rs_e_i))
            forward_a_e_o = FWD_M;
        else if (reg_write_w_i && reg_match(write_reg_w_i, rs_e_i))
            forward_a_e_o = FWD_W;
    end

    always_comb begin
        forward_b_e_o = FWD_RF;
        if (reg_write_m_i && reg_match(write_reg_m_i, rt_e_i))
            forward_b_e_o = FWD_M;
        else if (reg_write_w_i && reg_match(write_reg_w_i, rt_e_i))
            forward_b_e_o = FWD_W;
    end

    assign forward_a_d_o = reg_write_m_i && !mem_to_reg_m_i && reg_match(write_reg_m_i, rs_d_i);
    assign forward_b_d_o = reg_write_m_i && !mem_to_reg_m_i && reg_match(write_reg_m_i, rt_d_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: memory-wait FSM, syscall drain, timeout halt.
// Optional stall performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] write_reg_e,
    input  logic [REG_W-1:0] write_reg_m,
    input  logic [REG_W-1:0] write_reg_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    input  logic             mem_write_m,
    input  logic             branch_d,
    input  logic             syscall_m,
    input  logic             mem_ack,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             stall_m,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic             syscall_fire,
    output logic             halted,
    output logic [31:0]      stall_count
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [DRN_W-1:0] DRAIN_C   = DRN_W'(DRAIN_CYCLES);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             fire_q;

    logic load_use, branch_stall;
    logic in_run, in_wait, in_drain, in_halt;
    logic mem_stall, hz_stall;

    hazard_detect u_hazard_detect (
        .rs_d_i         (rs_d),
        .rt_d_i         (rt_d),
        .rs_e_i         (rs_e),
        .rt_e_i         (rt_e),
        .write_reg_e_i  (write_reg_e),
        .write_reg_m_i  (write_reg_m),
        .write_reg_w_i  (write_reg_w),
        .reg_write_e_i  (reg_write_e),
        .reg_write_m_i  (reg_write_m),
        .reg_write_w_i  (reg_write_w),
        .mem_to_reg_e_i (mem_to_reg_e),
        .mem_to_reg_m_i (mem_to_reg_m),
        .branch_d_i     (branch_d),
        .load_use_o     (load_use),
        .branch_stall_o (branch_stall),
        .forward_a_e_o  (forward_a_e),
        .forward_b_e_o  (forward_b_e),
        .forward_a_d_o  (forward_a_d),
        .forward_b_d_o  (forward_b_d)
    );

    assign in_run   = (state_q == RUN);
    assign in_wait  = (state_q == MEM_WAIT);
    assign in_drain = (state_q == SYS_DRAIN);
    assign in_halt  = (state_q == HALT);

    assign mem_stall = (mem_to_reg_m || mem_write_m) && !mem_ack && (in_run || in_wait);
    assign hz_stall  = (load_use || branch_stall) && in_run;

    assign wait_cnt_d  = wait_cnt_q + CNT_W'(1);
    assign drain_cnt_d = drain_cnt_q + DRN_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            fire_q      <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= CNT_W'(1);
                    end else if (syscall_m) begin
                        state_q     <= SYS_DRAIN;
                        drain_cnt_q <= DRN_W'(1);
                        fire_q      <= (DRAIN_C == DRN_W'(1));
                    end
                end
                MEM_WAIT: begin
                    // A late ack on the would-be timeout cycle still releases the pipeline.
                    if (mem_ack) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d == TIMEOUT_C)
                            state_q <= HALT;
                    end
                end
                SYS_DRAIN: begin
                    if (drain_cnt_q == DRAIN_C) begin
                        state_q     <= RUN;
                        drain_cnt_q <= '0;
                        fire_q      <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_d;
                        fire_q      <= (drain_cnt_d == DRAIN_C);
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign stall_f      = mem_stall || hz_stall || in_drain || in_halt;
    assign stall_d      = stall_f;
    assign flush_e      = hz_stall || in_drain || in_halt;
    assign stall_m      = mem_stall || in_halt;
    assign flush_w      = mem_stall || in_halt;
    assign syscall_fire = fire_q;
    assign halted       = in_halt;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count_q <= '0;
        else if (stall_f && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_q <= stall_count_q + 32'd1;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: random hazard/forwarding vectors
// against a rule-level model plus directed memory-wait, timeout and syscall scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 15;
    localparam int DR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m, mem_write_m, branch_d, syscall_m, mem_ack;
    logic       stall_f, stall_d, flush_e, stall_m, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       forward_a_d, forward_b_d, syscall_fire, halted;
    logic [31:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_CYCLES(DR)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
        .branch_d(branch_d), .syscall_m(syscall_m), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .stall_m(stall_m),
        .flush_w(flush_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .syscall_fire(syscall_fire), .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic dep(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
        {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
        {mem_write_m, branch_d, syscall_m, mem_ack} = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_tests++;
        if ({stall_f, stall_d, flush_e, stall_m, flush_w, forward_a_e, forward_b_e,
             forward_a_d, forward_b_d, syscall_fire, halted} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {stall_f, stall_d, flush_e, stall_m, flush_w, forward_a_e, forward_b_e,
                      forward_a_d, forward_b_d, syscall_fire, halted});
        end
        n_tests++;
        if (stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
        end
    endtask

    task automatic test_load_use();
        idle();
        mem_to_reg_e = 1'b1; write_reg_e = 5'd5; rs_d = 5'd5;
        #2;
        n_tests++;
        if ({stall_f, stall_d, flush_e} !== 3'b111) begin
            n_fail++;
            $display("FAIL load_use_hit: got %b expected 111", {stall_f, stall_d, flush_e});
        end
        tick();
        mem_to_reg_e = 1'b0; write_reg_e = 5'd0;
        #2;
        n_tests++;
        if ({stall_f, stall_d, flush_e} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_use_bubble: got %b expected 000", {stall_f, stall_d, flush_e});
        end
        tick();
        mem_to_reg_e = 1'b1; write_reg_e = 5'd0; rs_d = 5'd0; rt_d = 5'd0;
        #2;
        n_tests++;
        if ({stall_f, stall_d, flush_e} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_use_r0: got %b expected 000", {stall_f, stall_d, flush_e});
        end
        tick();
        idle();
    endtask

    task automatic test_forward_priority();
        idle();
        reg_write_m = 1'b1; reg_write_w = 1'b1;
        write_reg_m = 5'd7; write_reg_w = 5'd7; rs_e = 5'd7;
        #2;
        n_tests++;
        if (forward_a_e !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_m_priority: got %b expected 10", forward_a_e);
        end
        reg_write_m = 1'b0;
        #2;
        n_tests++;
        if (forward_a_e !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_w_only: got %b expected 01", forward_a_e);
        end
        tick();
        idle();
    endtask

    // Random hazard/forward vectors in RUN; memory accesses always zero-wait here.
    task automatic test_random_hazards(input int n);
        logic       lu, br, exp_stall, exp_ad, exp_bd;
        logic [1:0] exp_ae, exp_be;
        for (int i = 0; i < n; i++) begin
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3));
            write_reg_m = 5'($urandom_range(0, 3));
            write_reg_w = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            mem_to_reg_e = 1'($urandom); mem_to_reg_m = 1'($urandom);
            mem_write_m = 1'($urandom); branch_d = 1'($urandom);
            syscall_m = 1'b0; mem_ack = 1'b1;
            lu = mem_to_reg_e && (dep(write_reg_e, rs_d) || dep(write_reg_e, rt_d));
            br = branch_d && ((reg_write_e && (dep(write_reg_e, rs_d) || dep(write_reg_e, rt_d))) ||
                              (mem_to_reg_m && (dep(write_reg_m, rs_d) || dep(write_reg_m, rt_d))));
            exp_stall = lu || br;
            exp_ae = (reg_write_m && dep(write_reg_m, rs_e)) ? 2'b10 :
                     (reg_write_w && dep(write_reg_w, rs_e)) ? 2'b01 : 2'b00;
            exp_be = (reg_write_m && dep(write_reg_m, rt_e)) ? 2'b10 :
                     (reg_write_w && dep(write_reg_w, rt_e)) ? 2'b01 : 2'b00;
            exp_ad = reg_write_m && !mem_to_reg_m && dep(write_reg_m, rs_d);
            exp_bd = reg_write_m && !mem_to_reg_m && dep(write_reg_m, rt_d);
            #2;
            n_tests++;
            if ({stall_f, stall_d, flush_e, stall_m, flush_w} !==
                {exp_stall, exp_stall, exp_stall, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rand_stall[%0d]: got %b expected %b", i,
                         {stall_f, stall_d, flush_e, stall_m, flush_w},
                         {exp_stall, exp_stall, exp_stall, 2'b00});
            end
            n_tests++;
            if ({forward_a_e, forward_b_e, forward_a_d, forward_b_d} !==
                {exp_ae, exp_be, exp_ad, exp_bd}) begin
                n_fail++;
                $display("FAIL rand_fwd[%0d]: got %b expected %b", i,
                         {forward_a_e, forward_b_e, forward_a_d, forward_b_d},
                         {exp_ae, exp_be, exp_ad, exp_bd});
            end
            tick();
        end
        idle();
    endtask

    // Request held, ack arrives after n_wait non-ack cycles; expect exactly n_wait stall cycles.
    task automatic test_mem_wait(input int n_wait);
        int seen;
        idle();
        seen = 0;
        if ($urandom_range(0, 1) == 0) mem_to_reg_m = 1'b1;
        else mem_write_m = 1'b1;
        for (int c = 0; c <= n_wait; c++) begin
            mem_ack = (c == n_wait);
            #2;
            if (stall_m && flush_w && stall_f && stall_d) seen++;
            tick();
        end
        check($sformatf("mem_wait_%0d_stall_cycles", n_wait), 32'(seen), 32'(n_wait));
        idle();
        mem_to_reg_e = 1'b1; write_reg_e = 5'd3; rt_d = 5'd3;
        #2;
        check($sformatf("mem_wait_%0d_back_in_run", n_wait), {30'd0, flush_e, halted}, 32'b10);
        tick();
        idle();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        bad = 0;
        mem_to_reg_m = 1'b1; mem_ack = 1'b0;
        for (int c = 0; c < TO; c++) begin
            #2;
            if (halted !== 1'b0 || stall_m !== 1'b1) bad++;
            tick();
        end
        check("timeout_pre_halt", 32'(bad), 32'd0);
        #2;
        check("timeout_halt_outputs", {27'd0, halted, stall_f, stall_d, stall_m, flush_e & flush_w},
              32'b11111);
        idle();
        mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        #2;
        check("timeout_sticky", {30'd0, halted, flush_e}, 32'b11);
        do_reset();
        #2;
        check("timeout_reset_clears", {31'd0, halted}, 32'd0);
    endtask

    task automatic test_syscall();
        int fires;
        do_reset();
        fires = 0;
        syscall_m = 1'b1;
        #2;
        check("syscall_entry_no_stall", {31'd0, stall_f}, 32'd0);
        tick();
        syscall_m = 1'b0;
        for (int d = 1; d <= DR; d++) begin
            #2;
            check($sformatf("syscall_drain_%0d", d),
                  {27'd0, stall_f, stall_d, flush_e, stall_m, syscall_fire},
                  {27'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'(d == DR)});
            if (syscall_fire) fires++;
            tick();
        end
        #2;
        if (syscall_fire) fires++;
        check("syscall_after_drain", {30'd0, stall_f, flush_e}, 32'd0);
        check("syscall_fire_count", 32'(fires), 32'd1);
        tick();
    endtask

    task automatic test_syscall_reset();
        int fires;
        do_reset();
        fires = 0;
        syscall_m = 1'b1;
        tick();
        syscall_m = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("sys_reset_immediate", {30'd0, flush_e, syscall_fire}, 32'd0);
        tick();
        reset = 1'b0;
        for (int d = 0; d <= DR; d++) begin
            #2;
            if (syscall_fire || flush_e) fires++;
            tick();
        end
        check("sys_reset_no_pulse", 32'(fires), 32'd0);
    endtask

    // A syscall coinciding with a memory stall must not start a drain.
    task automatic test_mem_over_syscall();
        int drains;
        do_reset();
        drains = 0;
        syscall_m = 1'b1; mem_to_reg_m = 1'b1; mem_ack = 1'b0;
        #2;
        check("memsys_stall_m", {31'd0, stall_m}, 32'd1);
        tick();
        syscall_m = 1'b0; mem_ack = 1'b1;
        #2;
        check("memsys_released", {30'd0, stall_m, flush_e}, 32'd0);
        tick();
        idle();
        for (int d = 0; d <= DR; d++) begin
            #2;
            if (syscall_fire || flush_e) drains++;
            tick();
        end
        check("memsys_no_drain", 32'(drains), 32'd0);
    endtask

    task automatic test_perf_count();
        logic [31:0] exp;
        do_reset();
        mem_to_reg_e = 1'b1; write_reg_e = 5'd9; rs_d = 5'd9;
        for (int c = 0; c < 5; c++) tick();
        idle();
        tick();
        tick();
        #2;
`ifdef PIPE_PERF_CNT_EN
        exp = 32'd5;
`else
        exp = 32'd0;
`endif
        check("perf_stall_count", stall_count, exp);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_forward_priority();
        test_random_hazards(300);
        test_mem_wait(0);
        test_mem_wait(1);
        test_mem_wait(3);
        test_mem_wait(TO - 1);
        for (int k = 0; k < 4; k++) test_mem_wait($urandom_range(1, TO - 2));
        test_timeout();
        test_syscall();
        test_syscall_reset();
        test_mem_over_syscall();
        test_perf_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
